step_clk_ctrl: RTL

STEP_CLK_CTRL -- requirements
Module: step_clk_ctrl

---
 rtl/step_clk_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/step_clk_ctrl.sv
// ---------------------------------------------------------------------------
// step_clk_ctrl
//
// Single-step / free-run clock-enable controller for a slow demo CPU.
// Two raw push-buttons are synchronized and debounced; their debounced rising
// edges drive a two-state STOP/RUN machine that issues one-cycle cpu_ce
// pulses, either one per step press (STOP) or one every RUN_DIV cycles (RUN).
//
// Parameters
//   DB_N     debounce window in clock cycles (2 .. 2**20)
//   RUN_DIV  cpu_ce period in RUN mode, in clock cycles (2 .. 2**26)
//
// Ports
//   clock     in   sole clock, rising edge
//   reset     in   asynchronous, active-high reset
//   key_step  in   raw single-step button (asynchronous, bouncing)
//   key_run   in   raw run/stop toggle button (asynchronous, bouncing)
//   halt      in   synchronous halt request from the CPU (level)
//   cpu_ce    out  one-cycle CPU clock enable per CPU step
//   running   out  high while the controller is in RUN
//   step_cnt  out  cpu_ce pulses issued since reset (wraps at 16 bits)
// ---------------------------------------------------------------------------
module step_clk_ctrl #(
  parameter int unsigned DB_N    = 1000000,
  parameter int unsigned RUN_DIV = 25000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        key_step,
  input  logic        key_run,
  input  logic        halt,
  output logic        cpu_ce,
  output logic        running,
  output logic [15:0] step_cnt
);

  localparam int unsigned DB_W  = 20;
  localparam int unsigned DIV_W = 26;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_N - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  // Key index 0 is the step button, index 1 the run button.
  localparam int unsigned K_STEP = 0;
  localparam int unsigned K_RUN  = 1;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Key conditioning: 2-flop synchronizer, stability counter, debounced level,
  // and a registered rising-edge pulse.
  // -------------------------------------------------------------------------
  logic [1:0]      keys;
  logic [1:0]      sync1_q;
  logic [1:0]      sync2_q;
  logic [1:0]      db_q;
  logic [1:0]      db_dly_q;
  logic [1:0]      edge_q;
  logic [DB_W-1:0] stab_cnt_q [2];

  assign keys = {key_run, key_step};

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      edge_q   <= '0;
      // NOTE: the two stability counters are an array but only two entries,
      // so they are plain flops with a reset, not a RAM; clearing them here
      // guarantees a debounce in progress is abandoned on reset.
      for (int i = 0; i < 2; i++) begin
        stab_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= keys;
      sync2_q  <= sync1_q;
      db_dly_q <= db_q;
      // Edge pulse lands one cycle after the debounced level rises.
      edge_q   <= db_q & ~db_dly_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          stab_cnt_q[i] <= '0;
        end else if (stab_cnt_q[i] == DB_LAST) begin
          // Level has differed for DB_N consecutive cycles: accept it.
          db_q[i]       <= sync2_q[i];
          stab_cnt_q[i] <= '0;
        end else begin
          stab_cnt_q[i] <= stab_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  logic step_edge;
  logic run_edge;

  assign step_edge = edge_q[K_STEP];
  assign run_edge  = edge_q[K_RUN];

  // -------------------------------------------------------------------------
  // STOP/RUN state machine with run-mode divider.
  // -------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;
  logic             ce_d;
  logic [15:0]      step_cnt_q;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    ce_d    = 1'b0;
    case (state_q)
      ST_STOP: begin
        // Run wins over a simultaneous step; halt only blocks the run key.
        if (run_edge && !halt) begin
          state_d = ST_RUN;
          div_d   = '0;
        end else if (step_edge) begin
          ce_d = 1'b1;
        end
      end
      ST_RUN: begin
        // Halt or a run press leaves RUN and drops any pulse due this cycle;
        // step presses are ignored here.
        if (halt || run_edge) begin
          state_d = ST_STOP;
        end else if (div_q == DIV_LAST) begin
          ce_d  = 1'b1;
          div_d = '0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_STOP;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_STOP;
      div_q      <= '0;
      cpu_ce     <= 1'b0;
      running    <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cpu_ce     <= ce_d;
      running    <= (state_d == ST_RUN);
      // Counts the registered pulse, so it trails cpu_ce by one cycle.
      step_cnt_q <= step_cnt_q + {15'd0, cpu_ce};
    end
  end

  assign step_cnt = step_cnt_q;

endmodule
